regfile_multiport_sb: RTL

//  Parametrised multi-port integer register file for the pipelined core.

---
 rtl/regfile_multiport_sb_if.sv | 38 +++
 rtl/regfile_multiport_sb.sv | 123 ++++++++++++
 2 files changed

// File: rtl/regfile_multiport_sb_if.sv
// Register file access bundle: read ports, write ports, issue port and
// scoreboard status. The core (master) drives indices, write data and issue;
// the register file (slave) returns read data, busy flags and the pending count.
//   readreg     NRD*AW    read indices, port p at [p*AW +: AW]
//   readdata    NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
//   rd_busy     NRD       read source pending and not bypassed this cycle
//   regwrite    NWR       write enables
//   writereg    NWR*AW    write indices
//   writedata   NWR*XLEN  write data
//   issue_valid 1         producer issued this cycle
//   issue_reg   AW        destination of the issued producer
//   pend_cnt    AW+1      number of pending registers
interface regfile_multiport_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  logic [NRD*AW-1:0]   readreg;
  logic [NRD*XLEN-1:0] readdata;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      regwrite;
  logic [NWR*AW-1:0]   writereg;
  logic [NWR*XLEN-1:0] writedata;
  logic                issue_valid;
  logic [AW-1:0]       issue_reg;
  logic [AW:0]         pend_cnt;

  modport master (
    output readreg, regwrite, writereg, writedata, issue_valid, issue_reg,
    input  readdata, rd_busy, pend_cnt
  );
  modport slave (
    input  readreg, regwrite, writereg, writedata, issue_valid, issue_reg,
    output readdata, rd_busy, pend_cnt
  );
endinterface

// File: rtl/regfile_multiport_sb.sv
// Multi-port integer register file with same-cycle write->read bypass and a
// per-register pending scoreboard (issue sets, writeback clears).
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   rf       regfile_multiport_sb_if.slave bundle (reads, writes, issue, status)

// One read port: bypass from the highest matching write port, else storage.
module regfile_rd_lane #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic                          rst_n,
  input  logic [AW-1:0]                 raddr,
  input  logic [NREG-1:0][XLEN-1:0]     regs,
  input  logic [NREG-1:0]               pend,
  input  logic [NWR-1:0]                we,
  input  logic [NWR-1:0][AW-1:0]        waddr,
  input  logic [NWR-1:0][XLEN-1:0]      wdata,
  output logic [XLEN-1:0]               rdata,
  output logic                          busy
);
  logic            hit;
  logic [XLEN-1:0] byp;

  always_comb begin
    hit = 1'b0;
    byp = '0;
    // ascending scan: the last (highest) matching port wins
    for (int w = 0; w < NWR; w++) begin
      if (we[w] && (waddr[w] == raddr) && (raddr != '0)) begin
        hit = 1'b1;
        byp = wdata[w];
      end
    end
    // outputs are forced quiet while reset is held
    if (!rst_n || raddr == '0) rdata = '0;
    else if (hit)              rdata = byp;
    else                       rdata = regs[raddr];
    busy = rst_n && pend[raddr] && !hit;
  end
endmodule

module regfile_multiport_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  regfile_multiport_sb_if.slave rf
);
  logic [NWR-1:0]             we;
  logic [NWR-1:0][AW-1:0]     wa;
  logic [NWR-1:0][XLEN-1:0]   wd;
  logic [NRD-1:0][AW-1:0]     ra;
  logic [NRD-1:0][XLEN-1:0]   rd;
  logic [NRD-1:0]             busy;

  assign we = rf.regwrite;
  assign wa = rf.writereg;
  assign wd = rf.writedata;
  assign ra = rf.readreg;

  logic [NREG-1:0][XLEN-1:0]  regs_q, regs_d;
  logic [NREG-1:0]            pend_q, pend_d, set_m, clr_m;
  logic [AW:0]                cnt_q, cnt_d, n_clr;
  logic                       n_set;

  always_comb begin
    regs_d = regs_q;
    clr_m  = '0;
    set_m  = '0;
    // ascending port order: highest index write lands last
    for (int w = 0; w < NWR; w++) begin
      if (we[w] && wa[w] != '0) begin
        regs_d[wa[w]] = wd[w];
        clr_m[wa[w]]  = 1'b1;
      end
    end
    if (rf.issue_valid && rf.issue_reg != '0) set_m[rf.issue_reg] = 1'b1;
    // set wins over clear: the new producer supersedes the one writing back
    pend_d = (pend_q & ~clr_m) | set_m;
    n_set  = |(set_m & ~pend_q);
    n_clr  = '0;
    for (int r = 0; r < NREG; r++)
      n_clr = n_clr + {{AW{1'b0}}, pend_q[r] & clr_m[r] & ~set_m[r]};
    cnt_d = cnt_q + {{AW{1'b0}}, n_set} - n_clr;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_rd_lane #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NWR(NWR)) u_lane (
      .rst_n (reset_n),
      .raddr (ra[p]),
      .regs  (regs_q),
      .pend  (pend_q),
      .we    (we),
      .waddr (wa),
      .wdata (wd),
      .rdata (rd[p]),
      .busy  (busy[p])
    );
  end

  assign rf.readdata = rd;
  assign rf.rd_busy  = busy;
  assign rf.pend_cnt = cnt_q;
endmodule
